// File: rtl/mips_pkg.sv
// mips_pkg: shared MEM-stage types, write-back select encodings and datapath width default
package mips_pkg;
  localparam int N_DEF = 16;
  typedef enum logic [1:0] {IDLE, MEM_WAIT, IN_WAIT, OUT_WAIT} state_t;
  localparam logic [1:0] WB_ALU = 2'b00;
  localparam logic [1:0] WB_MEM = 2'b01;
  localparam logic [1:0] WB_PC  = 2'b10;
  localparam logic [1:0] WB_IN  = 2'b11;
endpackage

// File: rtl/mem_wb_latch.sv
// mem_wb_latch: MEM/WB pipeline register that inserts a bubble while the stage is stalled
module mem_wb_latch #(
  parameter int N = 16
)(
  input  logic         clk,
  input  logic         rst,
  input  logic         stall,
  input  logic         reg_write,
  input  logic [2:0]   write_reg,
  input  logic [N-1:0] data,
  output logic         wb_reg_write,
  output logic [2:0]   wb_write_reg,
  output logic [N-1:0] wb_data
);
  // load on advance; on stall only kill the write enable and hold the rest
  always_ff @(posedge clk) begin
    if (rst) begin
      wb_reg_write <= 1'b0;
      wb_write_reg <= '0;
      wb_data      <= '0;
    end else if (stall) begin
      wb_reg_write <= 1'b0;
    end else begin
      wb_reg_write <= reg_write;
      wb_write_reg <= write_reg;
      wb_data      <= data;
    end
  end
endmodule

// File: rtl/mem_stage_ctrl.sv
// mem_stage_ctrl: MEM-stage FSM for loads/stores/IN/OUT with pipeline stall; MEM_TIMEOUT_EN adds a wait timeout and sticky bus_err
module mem_stage_ctrl
  import mips_pkg::*;
#(
  parameter int N = N_DEF,
  parameter int TIMEOUT_CYC = 255
)(
  input  logic         clk,
  input  logic         rst,
  input  logic         mem_read,
  input  logic         mem_write,
  input  logic         io_in,
  input  logic         io_out,
  input  logic         reg_write,
  input  logic [1:0]   memtoreg,
  input  logic [2:0]   write_reg,
  input  logic [N-1:0] alu_out,
  input  logic [N-1:0] read_data1,
  input  logic [N-1:0] read_data2,
  input  logic [N-1:0] pc_adder_out,
  output logic         stall,
  output logic         bus_req,
  output logic         bus_we,
  output logic [N-1:0] bus_addr,
  output logic [N-1:0] bus_wdata,
  input  logic         bus_ack,
  input  logic [N-1:0] bus_rdata,
  output logic         in_ready,
  input  logic         in_valid,
  input  logic [N-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] out_data,
  output logic         wb_reg_write,
  output logic [2:0]   wb_write_reg,
  output logic [N-1:0] wb_data,
  output logic         bus_err
);
  state_t state, state_next;
  logic access, hs, to, done;
  logic [N-1:0] mem_q, in_q, mem_val, in_val, mem_now, in_now, wb_sel;
  assign access = mem_write | mem_read | io_out | io_in;
  assign hs = (state == MEM_WAIT && bus_ack) || (state == OUT_WAIT && out_ready) || (state == IN_WAIT && in_valid);
  assign done = hs | to;
`ifdef MEM_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYC + 1);
  logic [CW-1:0] cnt;
  logic err;
  assign to = state != IDLE && cnt == CW'(TIMEOUT_CYC - 1);
  assign bus_err = err;
  // count wait cycles from entry; latch an error when a wait expires unanswered
  always_ff @(posedge clk) begin
    cnt <= (rst || state == IDLE) ? '0 : cnt + CW'(1);
    err <= rst ? 1'b0 : err | (to & ~hs);
  end
`else
  assign to = 1'b0;
  assign bus_err = 1'b0;
`endif
  assign mem_val = to ? '0 : bus_rdata;
  assign in_val = to ? '0 : in_data;
  assign mem_now = state == MEM_WAIT ? mem_val : mem_q;
  assign in_now = state == IN_WAIT ? in_val : in_q;
  // capture load and IN data at completion
  always_ff @(posedge clk) begin
    if (rst) begin
      mem_q <= '0;
      in_q  <= '0;
    end else begin
      if (state == MEM_WAIT && done && !mem_write) mem_q <= mem_val;
      if (state == IN_WAIT && done) in_q <= in_val;
    end
  end
  // state register
  always_ff @(posedge clk) begin
    state <= rst ? IDLE : state_next;
  end
  // next state: one access per instruction, mem_write > mem_read > io_out > io_in
  always_comb begin
    state_next = state == IDLE ? ((mem_write | mem_read) ? MEM_WAIT : io_out ? OUT_WAIT : io_in ? IN_WAIT : IDLE)
               : done ? IDLE : state;
  end
  // stall and handshake outputs, idle values forced to zero
  always_comb begin
    stall     = state == IDLE ? access : ~done;
    bus_req   = state == MEM_WAIT;
    bus_we    = bus_req & mem_write;
    bus_addr  = bus_req ? alu_out : '0;
    bus_wdata = bus_req ? read_data2 : '0;
    out_valid = state == OUT_WAIT;
    out_data  = out_valid ? read_data1 : '0;
    in_ready  = state == IN_WAIT;
  end
  // write-back source select, bypassing the captured data in the completion cycle
  always_comb begin
    wb_sel = memtoreg == WB_MEM ? mem_now : memtoreg == WB_PC ? pc_adder_out : memtoreg == WB_IN ? in_now : alu_out;
  end
  mem_wb_latch #(.N(N)) u_wb (
    .clk          (clk),
    .rst          (rst),
    .stall        (stall),
    .reg_write    (reg_write),
    .write_reg    (write_reg),
    .data         (wb_sel),
    .wb_reg_write (wb_reg_write),
    .wb_write_reg (wb_write_reg),
    .wb_data      (wb_data)
  );
endmodule

// File: tb/tb_mem_stage_ctrl.sv
// tb_mem_stage_ctrl: scoreboard bench for mem_stage_ctrl; MEM_TIMEOUT_EN enables the timeout scenario
module tb_mem_stage_ctrl;
  logic clk = 0, rst = 0;
  logic mem_read = 0, mem_write = 0, io_in = 0, io_out = 0, reg_write = 0;
  logic [1:0] memtoreg = 0;
  logic [2:0] write_reg = 0;
  logic [15:0] alu_out = 0, read_data1 = 0, read_data2 = 0, pc_adder_out = 0;
  logic stall, bus_req, bus_we, in_ready, out_valid, wb_reg_write, bus_err;
  logic [15:0] bus_addr, bus_wdata, out_data, wb_data;
  logic [2:0] wb_write_reg;
  logic bus_ack = 0, in_valid = 0, out_ready = 0;
  logic [15:0] bus_rdata = 0, in_data = 0;
  int checks = 0, errors = 0;
  typedef struct {logic rw; logic [2:0] wr; logic [15:0] data;} exp_t;
  exp_t sb[$];

  mem_stage_ctrl #(.N(16), .TIMEOUT_CYC(4)) dut (
    .clk(clk), .rst(rst), .mem_read(mem_read), .mem_write(mem_write), .io_in(io_in), .io_out(io_out),
    .reg_write(reg_write), .memtoreg(memtoreg), .write_reg(write_reg), .alu_out(alu_out),
    .read_data1(read_data1), .read_data2(read_data2), .pc_adder_out(pc_adder_out), .stall(stall),
    .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_ack(bus_ack),
    .bus_rdata(bus_rdata), .in_ready(in_ready), .in_valid(in_valid), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .wb_reg_write(wb_reg_write),
    .wb_write_reg(wb_write_reg), .wb_data(wb_data), .bus_err(bus_err)
  );

  always #5 clk = ~clk;

  task automatic bubble();
    {mem_read, mem_write, io_in, io_out, reg_write} = '0;
    memtoreg = 0; write_reg = 0; alu_out = 0; read_data1 = 0; read_data2 = 0; pc_adder_out = 0;
    {bus_ack, in_valid, out_ready} = '0;
  endtask

  task automatic run(input logic mw, mr, oo, ii, rw, input logic [1:0] mt, input logic [2:0] wr,
                     input logic [15:0] alu, r1, r2, pc, rd, id, input int dly, input logic [15:0] exp_mem,
                     output int stalls);
    exp_t e;
    logic ereq, eout, ein;
    mem_write = mw; mem_read = mr; io_out = oo; io_in = ii; reg_write = rw; memtoreg = mt;
    write_reg = wr; alu_out = alu; read_data1 = r1; read_data2 = r2; pc_adder_out = pc;
    bus_rdata = rd; in_data = id;
    e.rw = rw; e.wr = wr;
    e.data = mt == 2'b00 ? alu : mt == 2'b01 ? exp_mem : mt == 2'b10 ? pc : id;
    sb.push_back(e);
    ereq = mw | mr; eout = !ereq & oo; ein = !ereq & !oo & ii;
    stalls = 0;
    for (int k = 0; ; k++) begin
      bus_ack = k > dly; out_ready = k > dly; in_valid = k > dly;
      #1;
      if (k > 0) begin
        checks++;
        if ({bus_req, bus_we, out_valid, in_ready} !== {ereq, mw, eout, ein})
          begin errors++; $display("FAIL handshake k=%0d got req/we/ov/ir=%b want %b", k, {bus_req, bus_we, out_valid, in_ready}, {ereq, mw, eout, ein}); end
        checks++;
        if ((ereq && (bus_addr !== alu || bus_wdata !== r2)) || (eout && out_data !== r1))
          begin errors++; $display("FAIL bus_data k=%0d got addr=%h wdata=%h out=%h want %h %h %h", k, bus_addr, bus_wdata, out_data, alu, r2, r1); end
        checks++;
        if (wb_reg_write !== 1'b0) begin errors++; $display("FAIL bubble k=%0d got wb_reg_write=%b want 0", k, wb_reg_write); end
      end
      if (!stall) break;
      stalls++;
      if (k == 40) begin errors++; $display("FAIL wait_bound got stall still 1 want release"); break; end
      @(negedge clk);
    end
    @(negedge clk);
    bubble();
    #1;
    e = sb.pop_front();
    checks++;
    if (wb_reg_write !== e.rw) begin errors++; $display("FAIL wb_reg_write got %b want %b", wb_reg_write, e.rw); end
    if (e.rw) begin
      checks++;
      if (wb_write_reg !== e.wr || wb_data !== e.data)
        begin errors++; $display("FAIL wb_result got reg=%0d data=%h want reg=%0d data=%h", wb_write_reg, wb_data, e.wr, e.data); end
    end
  endtask

  task automatic test_reset();
    bubble(); rst = 1;
    repeat (3) @(negedge clk);
    rst = 0; #1;
    checks++;
    if ({stall, bus_req, bus_we, in_ready, out_valid, wb_reg_write, bus_err} !== 7'b0 || bus_addr !== 0 ||
        bus_wdata !== 0 || out_data !== 0 || wb_data !== 0 || wb_write_reg !== 0)
      begin errors++; $display("FAIL reset got stall=%b req=%b ov=%b ir=%b wbrw=%b wbd=%h err=%b want all 0", stall, bus_req, out_valid, in_ready, wb_reg_write, wb_data, bus_err); end
  endtask

  task automatic test_alu();
    int s;
    run(0, 0, 0, 0, 1, 2'b00, 3, 16'h1234, 0, 0, 0, 0, 0, 0, 0, s);
    checks++;
    if (s != 0) begin errors++; $display("FAIL alu_stall got %0d want 0", s); end
    run(0, 0, 0, 0, 1, 2'b10, 5, 16'h1111, 0, 0, 16'h0102, 0, 0, 0, 0, s);
    checks++;
    if (s != 0) begin errors++; $display("FAIL pc_stall got %0d want 0", s); end
  endtask

  task automatic test_load();
    int s;
    run(0, 1, 0, 0, 1, 2'b01, 2, 16'h0040, 0, 0, 0, 16'hBEEF, 0, 3, 16'hBEEF, s);
    checks++;
    if (s != 4) begin errors++; $display("FAIL load_stall got %0d want 4", s); end
  endtask

  task automatic test_store();
    int s;
    run(1, 0, 0, 0, 0, 2'b00, 1, 16'h0010, 0, 16'h00AA, 0, 0, 0, 0, 0, s);
    checks++;
    if (s != 1) begin errors++; $display("FAIL store_stall got %0d want 1", s); end
  endtask

  task automatic test_io();
    int s;
    run(0, 0, 1, 0, 0, 2'b00, 0, 0, 16'h5A5A, 0, 0, 0, 0, 2, 0, s);
    checks++;
    if (s != 3) begin errors++; $display("FAIL out_stall got %0d want 3", s); end
    run(0, 0, 0, 1, 1, 2'b11, 6, 16'h9999, 0, 0, 0, 0, 16'h0007, 1, 0, s);
    checks++;
    if (s != 2) begin errors++; $display("FAIL in_stall got %0d want 2", s); end
  endtask

  task automatic test_priority();
    int s;
    run(0, 1, 0, 1, 1, 2'b01, 4, 16'h0080, 0, 0, 0, 16'hC0DE, 16'hFFFF, 1, 16'hC0DE, s);
    checks++;
    if (s != 2) begin errors++; $display("FAIL prio_stall got %0d want 2", s); end
  endtask

  task automatic test_back_to_back();
    int s;
    for (int i = 0; i < 3; i++) begin
      run(0, 1, 0, 0, 1, 2'b01, 3'(i + 1), 16'(i * 2), 0, 0, 0, 16'(16'hA000 + i), 0, i, 16'(16'hA000 + i), s);
      checks++;
      if (s != i + 1) begin errors++; $display("FAIL b2b_stall[%0d] got %0d want %0d", i, s, i + 1); end
    end
  endtask

  task automatic test_rst_abort();
    int s;
    mem_read = 1; reg_write = 1; memtoreg = 2'b01; write_reg = 7; alu_out = 16'h0200; bus_rdata = 16'hDEAD;
    repeat (2) @(negedge clk);
    rst = 1; bus_ack = 1; #1;
    checks++;
    if (bus_req !== 1'b1) begin errors++; $display("FAIL abort_pre got bus_req=%b want 1", bus_req); end
    @(negedge clk);
    rst = 0; bubble(); #1;
    checks++;
    if ({stall, bus_req, bus_we, in_ready, out_valid, wb_reg_write, bus_err} !== 7'b0 || bus_addr !== 0 || wb_data !== 0)
      begin errors++; $display("FAIL abort got stall=%b req=%b wbrw=%b wbd=%h want all 0", stall, bus_req, wb_reg_write, wb_data); end
    run(0, 0, 0, 0, 1, 2'b00, 1, 16'h4321, 0, 0, 0, 0, 0, 0, 0, s);
    checks++;
    if (s != 0) begin errors++; $display("FAIL abort_idle got %0d stalls want 0", s); end
  endtask

  task automatic test_timeout();
    int s;
`ifdef MEM_TIMEOUT_EN
    run(0, 1, 0, 0, 1, 2'b01, 2, 16'h0300, 0, 0, 0, 16'h7777, 0, 1000, 16'h0000, s);
    checks++;
    if (s != 4 || bus_err !== 1'b1) begin errors++; $display("FAIL timeout got stalls=%0d err=%b want 4 1", s, bus_err); end
    @(negedge clk); #1;
    checks++;
    if (bus_err !== 1'b1) begin errors++; $display("FAIL err_sticky got %b want 1", bus_err); end
`else
    s = 0;
    checks++;
    if (bus_err !== 1'b0) begin errors++; $display("FAIL err_tied got %b want 0", bus_err); end
`endif
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_alu();
    test_load();
    test_store();
    test_io();
    test_priority();
    test_back_to_back();
    test_rst_abort();
    test_timeout();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
